mod_pow2_scale: RTL and testbench
=================================

// Module: mod_pow2_scale
// PURPOSE
//  Computes result = (a * 2^shamt) mod n by iterative modular doubling.
//  Generalised successor of the fixed 256-bit x*2^256 mod N pre-scaler: width, shift count
//  and step rate are configurable, and it adds a busy/error handshake.
//  Sits in front of the Montgomery multiplier in the RSA datapath.
//  Converts operands into the Montgomery domain (shamt = NBITS).
// PARAMETERS
//  NBITS      256  operand/modulus width
//  MAX_SHIFT  256  largest legal shamt
//  SHW        9    shamt port width, must be >= clog2(MAX_SHIFT+1)
// PORTS
//  clk     in   1      rising-edge clock, single clock domain
//  rst_n   in   1      synchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  shamt   in   SHW    number of doublings
//  a       in   NBITS  operand; required a < n
//  n       in   NBITS  modulus; required n != 0
//  busy    out  1      high in CALC and DONE
//  done    out  1      one-cycle completion pulse
//  err     out  1      valid with done; illegal request
//  result  out  NBITS  held from done until the next accepted start
// BEHAVIOUR
//  Reset: rst_n=0 at a clk edge -> state IDLE, busy=0, done=0, err=0, result=0, counter=0.
//   Reset overrides everything and aborts a calculation in progress; no done is issued for it.
//  States IDLE -> CALC -> DONE -> IDLE.
//  IDLE:
//   - start=1 latches a, n and shamt into internal registers; inputs may change afterwards.
//   - Illegal request (n==0, a>=n, or shamt>MAX_SHIFT) -> DONE with err=1, result=0.
//   - Legal request with shamt==0 -> DONE with result=a.
//   - Any other legal request -> CALC with r=a and cnt=shamt.
//  CALC, one step per cycle:
//   - t = {r,1'b0}, held at NBITS+1 bits.
//   - r = (t >= n) ? t - n : t.
//   - cnt = cnt - 1; go to DONE after the step that makes cnt reach 0.
//   - Invariant r < n holds throughout, so one conditional subtract per step suffices.
//   - Comparison and subtract are done at NBITS+1 bits; no truncation before the compare.
//  DONE:
//   - done=1 for exactly one cycle; result=r is registered in the same edge.
//   - err is valid in that same cycle; next state IDLE.
//  Latency: start sampled at edge E0 -> done high during the cycle after edge E0+k.
//   - k = shamt for a legal request with shamt>0.
//   - k = 1 for shamt==0 or an illegal request.
//  Simultaneous events:
//   - start while busy=1 is ignored, not queued.
//   - start in the DONE cycle is also ignored.
//   - A new start is accepted on the first IDLE cycle.
//  result and err hold their values until the next accepted start.
//  Back-to-back throughput: one request per k+2 cycles.
// CONFIGURATION
//  MOD_SCALE_RADIX4_EN defined:
//   - CALC performs two cascaded doubling/reduce steps per cycle; cnt decrements by 2.
//   - If cnt==1, only one step is applied.
//   - Legal latency k = ceil(shamt/2).
//   - Results are identical to radix-2.
//  Undefined: single-step radix-2 datapath as described above.
// TESTING
//  1. NBITS=256; a=5, n=13, shamt=4.
//     -> result=2, err=0; done 4 cycles after start (2 with RADIX4_EN).
//  2. a=7, n=13, shamt=0.
//     -> result=7, err=0; done 1 cycle after start; busy high for 2 cycles total.
//  3. a=13, n=13, shamt=4; then a=1, n=0; then a=1, n=13, shamt=MAX_SHIFT+1.
//     -> each gives err=1, result=0; done 1 cycle after start.
//  4. a=192304, n=256'hE07122F2A4A9E81141ADE518A2CD7574DCB67060B005E24665EF532E0CCA73E1, shamt=256.
//     -> result equals the golden model (a<<256)%n; done at +256 (+128 with RADIX4_EN).
//  5. Test 4 again, with start pulsed at cycles +3 and +100 and a/n changed mid-run.
//     -> Single done only; result unchanged from test 4.
//  6. Test 4 again, with rst_n=0 at cycle +50 for 1 cycle.
//     -> busy=0, done=0, result=0 next cycle; no done follows.
//     -> A fresh start of test 1 then completes correctly.

Source files
------------

// File: rtl/mod_pow2_scale.sv
// rtl/mod_pow2_scale.sv - result = (a * 2^shamt) mod n by iterative modular doubling.
// Optional MOD_SCALE_RADIX4_EN: two doubling/reduce steps per CALC cycle.
module mod_pow2_scale #(
  parameter int NBITS     = 256,
  parameter int MAX_SHIFT = 256,
  parameter int SHW       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SHW-1:0]   shamt,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [SHW-1:0] MAX_S = SHW'(MAX_SHIFT);

  state_t           state_q, state_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [NBITS-1:0] n_q, n_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pend_err_q, pend_err_d;
  logic             illegal;
  logic [NBITS-1:0] step1;
  logic [NBITS-1:0] step2;

  // t stays NBITS+1 wide through the compare so the carry-out bit is never lost.
  function automatic logic [NBITS-1:0] mod_dbl(input logic [NBITS-1:0] r,
                                               input logic [NBITS-1:0] m);
    logic [NBITS:0] t;
    logic [NBITS:0] mx;
    t  = {r, 1'b0};
    mx = {1'b0, m};
    if (t >= mx) t = t - mx;
    return t[NBITS-1:0];
  endfunction

  assign illegal = (n == '0) || (a >= n) || (shamt > MAX_S);
  assign step1   = mod_dbl(r_q, n_q);
  assign step2   = mod_dbl(step1, n_q);

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pend_err_d = pend_err_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Illegal and zero-shift requests spend one no-step CALC cycle (cnt==0).
          n_d        = n;
          pend_err_d = illegal;
          r_d        = illegal ? '0 : a;
          cnt_d      = illegal ? '0 : shamt;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = r_q;
          err_d    = pend_err_q;
        end else begin
`ifdef MOD_SCALE_RADIX4_EN
          if (cnt_q == SHW'(1)) begin
            r_d      = step1;
            cnt_d    = '0;
            state_d  = S_DONE;
            result_d = step1;
            err_d    = pend_err_q;
          end else begin
            r_d   = step2;
            cnt_d = cnt_q - SHW'(2);
            if (cnt_q == SHW'(2)) begin
              state_d  = S_DONE;
              result_d = step2;
              err_d    = pend_err_q;
            end
          end
`else
          r_d   = step1;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d  = S_DONE;
            result_d = step1;
            err_d    = pend_err_q;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      pend_err_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      pend_err_q <= pend_err_d;
      result_q   <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_mod_pow2_scale.sv
// tb/tb_mod_pow2_scale.sv - directed self-checking bench for mod_pow2_scale.
// Honours MOD_SCALE_RADIX4_EN for expected latencies.
`timescale 1ns/1ps
module tb_mod_pow2_scale;
  localparam int NBITS     = 256;
  localparam int MAX_SHIFT = 256;
  localparam int SHW       = 9;
  localparam int TO        = 2000;
`ifdef MOD_SCALE_RADIX4_EN
  localparam bit R4 = 1'b1;
`else
  localparam bit R4 = 1'b0;
`endif
  localparam logic [NBITS-1:0] N4 =
    256'hE07122F2A4A9E81141ADE518A2CD7574DCB67060B005E24665EF532E0CCA73E1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [SHW-1:0]   shamt = '0;
  logic [NBITS-1:0] a = '0;
  logic [NBITS-1:0] n = '0;
  logic             busy, done, err;
  logic [NBITS-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_pow2_scale #(.NBITS(NBITS), .MAX_SHIFT(MAX_SHIFT), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shamt(shamt), .a(a), .n(n),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  function automatic logic illegal_req(input logic [NBITS-1:0] aa, input logic [NBITS-1:0] nn,
                                       input logic [SHW-1:0] s);
    return (nn == '0) || (aa >= nn) || (int'(s) > MAX_SHIFT);
  endfunction

  function automatic logic [NBITS-1:0] golden(input logic [NBITS-1:0] aa,
                                              input logic [NBITS-1:0] nn,
                                              input logic [SHW-1:0] s);
    logic [NBITS+MAX_SHIFT:0] big;
    logic [NBITS+MAX_SHIFT:0] mm;
    if (illegal_req(aa, nn, s)) return '0;
    big = {{(MAX_SHIFT+1){1'b0}}, aa};
    mm  = {{(MAX_SHIFT+1){1'b0}}, nn};
    big = big << s;
    big = big % mm;
    return big[NBITS-1:0];
  endfunction

  function automatic int exp_lat(input int s, input logic ill);
    if (ill || s == 0) return 1;
    return R4 ? (s + 1) / 2 : s;
  endfunction

  function automatic int lat_lit(input int r2, input int r4);
    return R4 ? r4 : r2;
  endfunction

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkw(input string nm, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: tracks accepted requests and their completion cycle.
  bit               chk_en = 1'b0;
  bit               m_act = 1'b0;
  int               m_cyc = 0;
  int               m_k = 0;
  logic [NBITS-1:0] m_res = '0;
  logic [NBITS-1:0] m_held = '0;
  logic             m_err = 1'b0;
  logic             m_held_err = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act      = 1'b0;
      m_held     = '0;
      m_held_err = 1'b0;
    end else if (m_act) begin
      m_cyc++;
      if (m_cyc > m_k) begin
        m_act      = 1'b0;
        m_held     = m_res;
        m_held_err = m_err;
      end
    end else if (start) begin
      m_act = 1'b1;
      m_cyc = 0;
      m_err = illegal_req(a, n, shamt);
      m_res = golden(a, n, shamt);
      m_k   = exp_lat(int'(shamt), m_err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("busy", busy, m_act);
      check1("done", done, m_act && (m_cyc == m_k));
      if (m_act && (m_cyc == m_k)) begin
        checkw("result_at_done", result, m_res);
        check1("err_at_done", err, m_err);
      end else if (!m_act) begin
        checkw("result_hold", result, m_held);
        check1("err_hold", err, m_held_err);
      end
    end
  end

  // Called at a negedge in an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic run_req(input logic [NBITS-1:0] aa, input logic [NBITS-1:0] nn,
                         input int s, output int lat,
                         output logic [NBITS-1:0] res, output logic er);
    a = aa; n = nn; shamt = SHW'(s); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < TO) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    er  = err;
    if (lat >= TO) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done within %0d", TO);
    end
    @(negedge clk);
  endtask

  task automatic expect_req(input string nm, input logic [NBITS-1:0] aa,
                            input logic [NBITS-1:0] nn, input int s,
                            input logic [NBITS-1:0] xres, input logic xerr, input int xlat);
    int lat;
    logic [NBITS-1:0] res;
    logic er;
    run_req(aa, nn, s, lat, res, er);
    checkw({nm, "_result"}, res, xres);
    check1({nm, "_err"}, er, xerr);
    checki({nm, "_latency"}, lat, xlat);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [NBITS-1:0] r4res;
    logic er;

    repeat (2) @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    checkw("rst_result", result, '0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    checkw("model_pin_t1", golden(256'd5, 256'd13, 9'd4), 256'd2);
    checkw("model_pin_max", golden(256'd1, 256'd13, 9'd256), 256'd3);

    expect_req("t1", 256'd5, 256'd13, 4, 256'd2, 1'b0, lat_lit(4, 2));
    expect_req("t2", 256'd7, 256'd13, 0, 256'd7, 1'b0, 1);
    expect_req("t3_a_eq_n", 256'd13, 256'd13, 4, 256'd0, 1'b1, 1);
    expect_req("t3_n_zero", 256'd1, 256'd0, 4, 256'd0, 1'b1, 1);
    expect_req("t3_shamt_big", 256'd1, 256'd13, MAX_SHIFT + 1, 256'd0, 1'b1, 1);
    expect_req("one_step", 256'd12, 256'd13, 1, 256'd11, 1'b0, 1);
    expect_req("odd_shift", 256'd12, 256'd13, 3, 256'd5, 1'b0, lat_lit(3, 2));
    expect_req("n_one", 256'd0, 256'd1, 5, 256'd0, 1'b0, lat_lit(5, 3));
    expect_req("max_shift", 256'd1, 256'd13, MAX_SHIFT, 256'd3, 1'b0, lat_lit(256, 128));

    run_req(256'd192304, N4, 256, lat, r4res, er);
    checkw("t4_result", r4res, golden(256'd192304, N4, 9'd256));
    check1("t4_err", er, 1'b0);
    checki("t4_latency", lat, lat_lit(256, 128));

    // Test 5: starts while busy and input changes must not disturb the run.
    a = 256'd192304; n = N4; shamt = 9'd256; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    ndone = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) ndone++;
      start = (lat == 3 || lat == 100);
      if (lat == 3) begin a = 256'd99; n = 256'd7; end
      if (lat == 100) begin a = 256'd1; n = 256'd0; end
    end
    checki("t5_done_count", ndone, 1);
    checkw("t5_result", result, r4res);

    // Test 6: reset mid-run aborts without a done.
    a = 256'd192304; n = N4; shamt = 9'd256; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check1("t6_busy", busy, 1'b0);
    check1("t6_done", done, 1'b0);
    check1("t6_err", err, 1'b0);
    checkw("t6_result", result, '0);
    ndone = 0;
    repeat (300) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checki("t6_no_done", ndone, 0);
    expect_req("t6_t1", 256'd5, 256'd13, 4, 256'd2, 1'b0, lat_lit(4, 2));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
